// File: rtl/change_dispenser.sv
// Change payout FSM: pays an owed cent amount one coin at a time over a level/ack handshake.
// Optional macro CHANGE_DISPENSER_ACK_TIMEOUT_EN adds an ack timeout in PRESENT.
module change_dispenser #(
  parameter int W           = 10,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25,
  parameter int DOLLAR_VAL  = 100,
  parameter int CNT_W       = 7,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     change_in,
  input  logic             abort,
  input  logic             coin_ack,
  output logic             dime_out,
  output logic             quarter_out,
  output logic             dollar_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     remaining,
  output logic [CNT_W-1:0] coin_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SELECT  = 3'd2,
    S_PRESENT = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t           state_q;
  logic             dime_q, quarter_q, dollar_q;
  logic             busy_q, done_q, err_q;
  logic [W-1:0]     rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W-1:0]     rem_dollar_s, rem_quarter_s, coin_val_s, rem_after_s;
  logic             pick_dollar_s, pick_quarter_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             tmo_hit_s;

  // Amounts that can be paid exactly with dimes, quarters and dollars.
  function automatic logic payable(input logic [W-1:0] x);
    payable = ((x % W'(5)) == W'(0)) && (x != W'(5)) && (x != W'(15));
  endfunction

  // Coin choice for SELECT and decrement for the coin currently presented.
  always_comb begin
    rem_dollar_s   = rem_q - W'(DOLLAR_VAL);
    rem_quarter_s  = rem_q - W'(QUARTER_VAL);
    pick_dollar_s  = (rem_q >= W'(DOLLAR_VAL)) && payable(rem_dollar_s);
    pick_quarter_s = (rem_q >= W'(QUARTER_VAL)) && payable(rem_quarter_s);
    if (dollar_q) begin
      coin_val_s = W'(DOLLAR_VAL);
    end else if (quarter_q) begin
      coin_val_s = W'(QUARTER_VAL);
    end else if (dime_q) begin
      coin_val_s = W'(DIME_VAL);
    end else begin
      coin_val_s = W'(0);
    end
    rem_after_s = rem_q - coin_val_s;
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end
  end

`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // Ack wait counter; zero outside PRESENT so it restarts for every coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= TW'(0);
    end else if (state_q != S_PRESENT) begin
      tmo_q <= TW'(0);
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign tmo_hit_s = (state_q == S_PRESENT) && (tmo_q == TW'(ACK_TIMEOUT - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Payout FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
      dollar_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rem_q     <= W'(0);
      cnt_q     <= CNT_W'(0);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q   <= change_in;
            cnt_q   <= CNT_W'(0);
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (rem_q == W'(0)) begin
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (!payable(rem_q)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (abort) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            dollar_q  <= pick_dollar_s;
            quarter_q <= !pick_dollar_s && pick_quarter_s;
            dime_q    <= !pick_dollar_s && !pick_quarter_s;
            state_q   <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (coin_ack) begin
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            dollar_q  <= 1'b0;
            rem_q     <= rem_after_s;
            cnt_q     <= cnt_inc_s;
            if (rem_after_s == W'(0)) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else if (abort) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              state_q <= S_SELECT;
            end
          end else if (abort || tmo_hit_s) begin
            // Coin withdrawn unpaid, so the owed amount stays intact.
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            dollar_q  <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            state_q <= S_PRESENT;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          dime_q    <= 1'b0;
          quarter_q <= 1'b0;
          dollar_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign dime_out    = dime_q;
  assign quarter_out = quarter_q;
  assign dollar_out  = dollar_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign remaining   = rem_q;
  assign coin_cnt    = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; flags vector is {dollar,quarter,dime,busy,done,err}.
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] change_in;
  logic       abort;
  logic       coin_ack;
  logic       dime_out, quarter_out, dollar_out;
  logic       busy, done, err;
  logic [9:0] remaining;
  logic [6:0] coin_cnt;

  int n_run  = 0;
  int n_fail = 0;

  change_dispenser #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .change_in(change_in),
    .abort(abort), .coin_ack(coin_ack),
    .dime_out(dime_out), .quarter_out(quarter_out), .dollar_out(dollar_out),
    .busy(busy), .done(done), .err(err),
    .remaining(remaining), .coin_cnt(coin_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] f, input logic [9:0] r, input logic [6:0] c);
    chk({tag, "_flags"}, {26'd0, dollar_out, quarter_out, dime_out, busy, done, err}, {26'd0, f});
    chk({tag, "_rem"}, {22'd0, remaining}, {22'd0, r});
    chk({tag, "_cnt"}, {25'd0, coin_cnt}, {25'd0, c});
  endtask

  task automatic step(input string tag, input logic [5:0] f, input logic [9:0] r, input logic [6:0] c);
    tick();
    chk_all(tag, f, r, c);
  endtask

  // Pulse start for one cycle and check the LOAD cycle.
  task automatic kick(input string tag, input logic [9:0] amt);
    change_in = amt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all({tag, "_load"}, 6'b000_100, amt, 7'd0);
  endtask

  task automatic wait_coin(input string tag, input logic [2:0] expc);
    int k;
    k = 0;
    while (({dollar_out, quarter_out, dime_out} == 3'b000) && (k < 6)) begin
      tick();
      k++;
    end
    chk({tag, "_coin"}, {29'd0, dollar_out, quarter_out, dime_out}, {29'd0, expc});
  endtask

  initial begin
    logic [2:0] expc;
    rst_n = 1'b0; start = 1'b0; change_in = 10'd0; abort = 1'b0; coin_ack = 1'b0;
    tick(); tick();
    chk_all("rst", 6'b000_000, 10'd0, 7'd0);
    rst_n = 1'b1;
    step("idle", 6'b000_000, 10'd0, 7'd0);

    // 130 with ack tied high: dollar, dime, dime, dime.
    coin_ack = 1'b1;
    kick("A", 10'd130);
    step("A2",  6'b000_100, 10'd130, 7'd0);
    step("A3",  6'b100_100, 10'd130, 7'd0);
    step("A4",  6'b000_100, 10'd30,  7'd1);
    step("A5",  6'b001_100, 10'd30,  7'd1);
    step("A6",  6'b000_100, 10'd20,  7'd2);
    step("A7",  6'b001_100, 10'd20,  7'd2);
    step("A8",  6'b000_100, 10'd10,  7'd3);
    step("A9",  6'b001_100, 10'd10,  7'd3);
    step("A10", 6'b000_110, 10'd0,   7'd4);
    step("A11", 6'b000_000, 10'd0,   7'd4);
    coin_ack = 1'b0;

    // 65 with ack on the third cycle of each coin: quarter then four dimes.
    kick("B", 10'd65);
    for (int i = 0; i < 5; i++) begin
      expc = (i == 0) ? 3'b010 : 3'b001;
      wait_coin("B", expc);
      repeat (2) begin
        tick();
        chk("B_hold", {29'd0, dollar_out, quarter_out, dime_out}, {29'd0, expc});
      end
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      chk("B_drop", {29'd0, dollar_out, quarter_out, dime_out}, 32'd0);
      chk("B_rem", {22'd0, remaining}, 32'd40 - 32'd10 * i);
      chk("B_cnt", {25'd0, coin_cnt}, i + 1);
    end
    chk_all("B_fin", 6'b000_110, 10'd0, 7'd5);
    step("B_idle", 6'b000_000, 10'd0, 7'd5);

    // Unpayable 15, then zero.
    kick("C15", 10'd15);
    step("C15_fin",  6'b000_111, 10'd15, 7'd0);
    step("C15_idle", 6'b000_001, 10'd15, 7'd0);
    kick("C0", 10'd0);
    step("C0_fin",  6'b000_110, 10'd0, 7'd0);
    step("C0_idle", 6'b000_000, 10'd0, 7'd0);

    // 200: abort while second dollar is presented without ack.
    kick("D", 10'd200);
    step("D2", 6'b000_100, 10'd200, 7'd0);
    step("D3", 6'b100_100, 10'd200, 7'd0);
    coin_ack = 1'b1;
    step("D4", 6'b000_100, 10'd100, 7'd1);
    coin_ack = 1'b0;
    step("D5", 6'b100_100, 10'd100, 7'd1);
    step("D6", 6'b100_100, 10'd100, 7'd1);
    abort = 1'b1;
    step("D7", 6'b000_111, 10'd100, 7'd1);
    abort = 1'b0;
    step("D8", 6'b000_001, 10'd100, 7'd1);

    // Ack and abort together with change still owed, then on the final coin.
    kick("E", 10'd35);
    step("E2", 6'b000_100, 10'd35, 7'd0);
    step("E3", 6'b010_100, 10'd35, 7'd0);
    coin_ack = 1'b1; abort = 1'b1;
    step("E4", 6'b000_111, 10'd10, 7'd1);
    coin_ack = 1'b0; abort = 1'b0;
    step("E5", 6'b000_001, 10'd10, 7'd1);
    kick("F", 10'd10);
    step("F2", 6'b000_100, 10'd10, 7'd0);
    step("F3", 6'b001_100, 10'd10, 7'd0);
    coin_ack = 1'b1; abort = 1'b1;
    step("F4", 6'b000_110, 10'd0, 7'd1);
    coin_ack = 1'b0; abort = 1'b0;
    step("F5", 6'b000_000, 10'd0, 7'd1);

    // start held and re-pulsed while busy is ignored.
    change_in = 10'd25;
    start = 1'b1;
    step("G1", 6'b000_100, 10'd25, 7'd0);
    change_in = 10'd100;
    step("G2", 6'b000_100, 10'd25, 7'd0);
    start = 1'b0;
    step("G3", 6'b010_100, 10'd25, 7'd0);
    start = 1'b1;
    step("G4", 6'b010_100, 10'd25, 7'd0);
    start = 1'b0;
    coin_ack = 1'b1;
    step("G5", 6'b000_110, 10'd0, 7'd1);
    coin_ack = 1'b0;
    step("G6", 6'b000_000, 10'd0, 7'd1);

    // Asynchronous reset while a quarter is presented.
    kick("R", 10'd25);
    step("R2", 6'b000_100, 10'd25, 7'd0);
    step("R3", 6'b010_100, 10'd25, 7'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("R_async", 6'b000_000, 10'd0, 7'd0);
    step("R_hold", 6'b000_000, 10'd0, 7'd0);
    rst_n = 1'b1;
    coin_ack = 1'b1;
    kick("R_after", 10'd10);
    step("R_after2", 6'b000_100, 10'd10, 7'd0);
    step("R_after3", 6'b001_100, 10'd10, 7'd0);
    step("R_after4", 6'b000_110, 10'd0, 7'd1);
    step("R_after5", 6'b000_000, 10'd0, 7'd1);
    coin_ack = 1'b0;

    // Dime with no ack: timeout after 4 cycles, or indefinite wait.
    kick("T", 10'd10);
    step("T2", 6'b000_100, 10'd10, 7'd0);
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
    repeat (4) step("T_dime", 6'b001_100, 10'd10, 7'd0);
    step("T_tmo",  6'b000_111, 10'd10, 7'd0);
    step("T_idle", 6'b000_001, 10'd10, 7'd0);
`else
    repeat (8) step("T_wait", 6'b001_100, 10'd10, 7'd0);
    coin_ack = 1'b1;
    step("T_ack", 6'b000_110, 10'd0, 7'd1);
    coin_ack = 1'b0;
    step("T_idle", 6'b000_000, 10'd0, 7'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
